serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands one bit per clock through a single full-adder cell and a registered carry. It sits between operand producers and result consumers on a valid/ready handshake, and trades latency for area against a parallel ripple-carry chain of full adders. It accepts one operation at a time and presents sum plus carry-out when done.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and carry_in are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A; sampled on acceptance.
- b  input  WIDTH  operand B; sampled on acceptance.
- carry_in  input  1  initial carry; sampled on acceptance.
- out_valid  output  1  sum and carry_out hold a completed result.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result a + b + carry_in, modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow; present only with SERIAL_ADDER_OVERFLOW_EN.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a and b into shift registers, load carry register with carry_in, clear bit counter, go to RUN.
- RUN: each cycle, bit i = LSB of both shift registers plus carry register goes through the full-adder function. s = a_i ^ b_i ^ c. c_next = (a_i & b_i) | (c & (a_i ^ b_i)).
- RUN, per cycle: shift operand registers right by one. Shift s into the MSB of the internal sum shift register. Update the carry register. Increment the counter.
- RUN ends on the cycle the counter is WIDTH-1. On that edge, copy the final internal sum into the sum output register. Copy c_next into carry_out. Go to DONE.
- DONE: out_valid=1. On out_valid && out_ready, go to IDLE.
- sum and carry_out are registered. They change only on the RUN→DONE edge and hold their value through DONE, IDLE and the next RUN.
- in_valid is ignored outside IDLE; no operand is latched and no error is raised.
- Reset (any state, asynchronous):
  - State goes to IDLE; the in-flight operation is discarded.
  - Reset values: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0.
  - All internal shift registers, the counter and the carry register clear to 0.

## Timing
- Acceptance edge is T. RUN spans edges T+1 .. T+WIDTH. out_valid rises after edge T+WIDTH. Latency is WIDTH cycles.
- Result handshake on edge U: out_valid falls and in_ready rises after U. There is no same-cycle re-accept.
- Minimum issue interval is WIDTH+2 cycles when out_ready is held high.
- out_ready low in DONE stalls indefinitely. Outputs stay stable, in_ready stays 0.
- out_ready and in_valid asserted outside their states have no effect.
- The counter is $clog2(WIDTH) bits wide and wraps to 0 on the DONE transition.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN defined:
  - Adds the overflow output.
  - A one-bit register captures the carry into bit WIDTH-1 during the last RUN cycle.
  - overflow = that carry ^ carry_out. It is registered and updates alongside sum, with the same hold behaviour.
- Not defined: no overflow port and no extra registers. Every other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, carry_in=0 → out_valid exactly 8 cycles after acceptance; sum=0x96, carry_out=0.
- a=0xFF, b=0x01, carry_in=0 → sum=0x00, carry_out=1. Then a=0xFF, b=0xFF, carry_in=1 → sum=0xFF, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → sum/carry_out unchanged, in_ready=0, new operands not taken. The first result completes after out_ready=1.
- Assert rst_n=0 on the 4th RUN cycle → out_valid=0, sum=0, in_ready=1 immediately. After release, a=0x01, b=0x02 → sum=0x03.
- Back-to-back with out_ready tied 1 → acceptances spaced exactly 10 cycles apart (WIDTH=8).
- With SERIAL_ADDER_OVERFLOW_EN: 0x7F+0x01 → sum=0x80, carry_out=0, overflow=1. 0x80+0x80 → sum=0x00, carry_out=1, overflow=1. 0x40+0x20 → overflow=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder with one full-adder cell and a registered carry.
// Adds a + b + carry_in one bit per clock behind valid/ready handshakes.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add a registered
// signed-overflow output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, a_sh_next;
    logic [WIDTH-1:0] b_sh, b_sh_next;
    logic [WIDTH-1:0] s_sh, s_sh_next;
    logic             carry, carry_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] sum_next;
    logic             carry_out_next;
    logic             fa_s;
    logic             fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow_next;
`endif

    // Full-adder cell on the current LSBs and the carry register.
    always_comb begin
        fa_s = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_next     = state;
        a_sh_next      = a_sh;
        b_sh_next      = b_sh;
        s_sh_next      = s_sh;
        carry_next     = carry;
        cnt_next       = cnt;
        sum_next       = sum;
        carry_out_next = carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        overflow_next  = overflow;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = carry_in;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next  = {1'b0, a_sh[WIDTH-1:1]};
                b_sh_next  = {1'b0, b_sh[WIDTH-1:1]};
                s_sh_next  = {fa_s, s_sh[WIDTH-1:1]};
                carry_next = fa_c;
                cnt_next   = cnt + CW'(1);
                if (cnt == LAST) begin
                    sum_next       = {fa_s, s_sh[WIDTH-1:1]};
                    carry_out_next = fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // Carry into the MSB differs from carry out of it.
                    overflow_next  = carry ^ fa_c;
`endif
                    cnt_next       = '0;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            a_sh      <= a_sh_next;
            b_sh      <= b_sh_next;
            s_sh      <= s_sh_next;
            carry     <= carry_next;
            cnt       <= cnt_next;
            sum       <= sum_next;
            carry_out <= carry_out_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= overflow_next;
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven, directed and random checks of serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         ovf_dut;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .carry_in(carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .carry_out(carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow(ovf_dut)
`endif
    );

`ifndef SERIAL_ADDER_OVERFLOW_EN
    assign ovf_dut = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        logic         exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // One full transaction: accept, measure latency, optional stall, handshake.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int stall, output logic [W-1:0] rs, output logic rco,
                          output logic rov);
        int n;
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        a = ta; b = tb; carry_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; carry_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(W));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        rs = sum; rco = carry_out; rov = ovf_dut;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after_handshake_out_valid", 64'(out_valid), 64'd0);
        check("after_handshake_in_ready", 64'(in_ready), 64'd1);
        check("after_handshake_sum_hold", 64'(sum), 64'(rs));
    endtask

    initial begin
        logic [W-1:0] rs, es;
        logic         rco, rov, eco, eov;
        int           acc[3];
        int           n_acc, cyc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset values
        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_carry_out", 64'(carry_out), 64'd0);
        check("reset_overflow", 64'(ovf_dut), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, rs, rco, rov);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry_out", i), 64'(rco), 64'(vecs[i].exp_co));
`ifdef SERIAL_ADDER_OVERFLOW_EN
            check($sformatf("vec%0d_overflow", i), 64'(rov), 64'(vecs[i].exp_ov));
`endif
        end

        // Backpressure: DONE held for 5 cycles while new operands are offered
        @(negedge clk);
        a = 8'h12; b = 8'h34; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'(W));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'hAA; b = 8'h55; carry_in = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_sum", 64'(sum), 64'h46);
            check("bp_carry_out", 64'(carry_out), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_no_extra_op", 64'(in_ready), 64'd1);
        end

        // Reset on the 4th RUN cycle
        @(negedge clk);
        a = 8'hC3; b = 8'h11; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_out_valid", 64'(out_valid), 64'd0);
        check("midrun_reset_sum", 64'(sum), 64'd0);
        check("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 1'b0, 0, rs, rco, rov);
        check("post_reset_sum", 64'(rs), 64'h03);
        check("post_reset_carry_out", 64'(rco), 64'd0);

        // Back-to-back with out_ready tied high
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h21; b = 8'h43; carry_in = 1'b0;
        n_acc = 0; cyc = 0;
        while (n_acc < 3 && cyc < 100) begin
            if (in_ready) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_accept_count", 64'(n_acc), 64'd3);
        if (n_acc == 3) begin
            check("b2b_interval0", 64'(acc[1] - acc[0]), 64'(W + 2));
            check("b2b_interval1", 64'(acc[2] - acc[1]), 64'(W + 2));
        end
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_sum", 64'(sum), 64'h64);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_drained", 64'(in_ready), 64'd1);

        // Random operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco, eov);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), rs, rco, rov);
            check("rand_sum", 64'(rs), 64'(es));
            check("rand_carry_out", 64'(rco), 64'(eco));
`ifdef SERIAL_ADDER_OVERFLOW_EN
            check("rand_overflow", 64'(rov), 64'(eov));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, got running expected finished");
        $fatal(1);
    end

endmodule
